// File: rtl/soc_system_pkg.sv
// rtl/soc_system_pkg.sv - shared types and constants for the system-ID checker
package soc_system_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_DONE    = 3'd5
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'hACD5_1302;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h5711_7CE3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/soc_system_sysid_checker.sv
// rtl/soc_system_sysid_checker.sv - Avalon-MM read master confirming the loaded image's system ID and timestamp
module soc_system_sysid_checker
    import soc_system_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sysid_state_e   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic           in_txn;
    logic           expired;
    logic           accept_start;
    logic           capture_id;
    logic           capture_ts;
    logic           abort;
    logic           enter_req;

    assign in_txn  = (state == S_ID_REQ) || (state == S_ID_WAIT) ||
                     (state == S_TS_REQ) || (state == S_TS_WAIT);
    assign expired = in_txn && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A completed handshake in the same cycle the budget runs out still counts as progress.
    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        capture_id   = 1'b0;
        capture_ts   = 1'b0;
        abort        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_ID_REQ;
                    accept_start = 1'b1;
                end
            end
            S_ID_REQ: begin
                if (!avm_waitrequest) state_nxt = S_ID_WAIT;
                else if (expired)     abort     = 1'b1;
            end
            S_ID_WAIT: begin
                if (avm_readdatavalid) begin
                    capture_id = 1'b1;
                    state_nxt  = S_TS_REQ;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_TS_REQ: begin
                if (!avm_waitrequest) state_nxt = S_TS_WAIT;
                else if (expired)     abort     = 1'b1;
            end
            S_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    capture_ts = 1'b1;
                    state_nxt  = S_DONE;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_DONE;
    end

    assign enter_req = (state_nxt != state) &&
                       ((state_nxt == S_ID_REQ) || (state_nxt == S_TS_REQ));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            if (enter_req)   cnt <= '0;
            else if (in_txn) cnt <= cnt + 1'b1;

            avm_read <= (state_nxt == S_ID_REQ) || (state_nxt == S_TS_REQ);
            if (enter_req) begin
                avm_address <= (state_nxt == S_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            end

            busy <= (state_nxt != S_IDLE);
            done <= (state == S_DONE);

            if (accept_start) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                pass    <= 1'b0;
                timeout <= 1'b0;
            end
            if (capture_id) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (capture_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (abort) timeout <= 1'b1;
            if (state == S_DONE) pass <= id_ok && ts_ok && !timeout;
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// tb/tb_soc_system_sysid_checker.sv - self-checking bench for soc_system_sysid_checker
module tb_soc_system_sysid_checker;
    import soc_system_pkg::*;

    localparam int TO = 16;
    localparam logic [31:0] EXP_ID = 32'hACD5_1302;
    localparam logic [31:0] EXP_TS = 32'h5711_7CE3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, pass, timeout;
    logic [31:0] id_value, ts_value;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;
    int r_wi, r_li, r_wt, r_lt;
    logic [31:0] r_di, r_dt;

    always #5 clock = ~clock;

    soc_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy),
        .done(done),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .pass(pass),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":read"}, avm_read, 0);
        check({tag, ":addr"}, avm_address, 0);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":flags"}, {id_ok, ts_ok, pass, timeout}, 0);
        check({tag, ":id_value"}, id_value, 0);
        check({tag, ":ts_value"}, ts_value, 0);
    endtask

    // Slave behaviour: w* stall cycles before acceptance, data l* cycles after acceptance.
    task automatic run_check(input string name, input int w_id, input int l_id,
                             input int w_ts, input int l_ts,
                             input logic [31:0] d_id, input logic [31:0] d_ts,
                             input bit stuck, input int restart_at, input int reset_at);
        int n, wcnt, pend, done_edge, done_cnt, n_reads, exp_edge, last_read;
        bit acc, saw_ts;
        logic acc_addr, data_addr;
        logic e_id_ok, e_ts_ok;
        exp_edge  = stuck ? TO + 1 : (1 + w_id + l_id) + (1 + w_ts + l_ts) + 1;
        wcnt      = w_id;
        pend      = 0;
        acc       = 0;
        acc_addr  = 0;
        data_addr = 0;
        done_edge = -1;
        done_cnt  = 0;
        n_reads   = 0;
        last_read = -1;
        saw_ts    = 0;
        if (!stuck) begin
            m_id = d_id;
            m_ts = d_ts;
        end
        e_id_ok = !stuck && (d_id == EXP_ID);
        e_ts_ok = !stuck && (d_ts == EXP_TS);

        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        n = 0;
        @(negedge clock);
        check({name, ":busy_E0"}, busy, 1);
        check({name, ":read_E0"}, avm_read, 1);
        while (1) begin
            if (n == reset_at) begin
                #2 reset_n = 1'b0;
                #1;
                m_id = '0;
                m_ts = '0;
                check_all_zero({name, ":async_reset"});
                start = 1'b0;
                avm_waitrequest = 1'b0;
                avm_readdatavalid = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
            start = (n == restart_at);
            if (done && done_edge < 0) begin
                done_edge = n;
                check({name, ":id_ok"}, id_ok, e_id_ok);
                check({name, ":ts_ok"}, ts_ok, e_ts_ok);
                check({name, ":pass"}, pass, e_id_ok && e_ts_ok && !stuck);
                check({name, ":timeout"}, timeout, stuck);
                check({name, ":id_value"}, id_value, m_id);
                check({name, ":ts_value"}, ts_value, m_ts);
            end
            if (done) done_cnt++;
            if (done_edge < 0 && !done) check({name, ":busy_during"}, busy, 1);
            if (avm_read) last_read = n;
            if (avm_read && avm_address) saw_ts = 1;

            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            avm_readdata = $urandom;
            if (acc) begin
                pend = acc_addr ? l_ts : l_id;
                data_addr = acc_addr;
                acc = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = data_addr ? d_ts : d_id;
                end
            end
            if (avm_read) begin
                check({name, ":addr"}, avm_address, (n_reads == 0) ? 0 : 1);
                if (stuck || wcnt > 0) begin
                    avm_waitrequest = 1'b1;
                    if (wcnt > 0) wcnt--;
                end else begin
                    acc = 1;
                    acc_addr = avm_address;
                    n_reads++;
                    wcnt = w_ts;
                end
            end
            if (done_edge >= 0 && n >= done_edge + 2) break;
            if (n >= 60) break;
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        start = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        check({name, ":done_edge"}, done_edge, exp_edge);
        check({name, ":done_pulses"}, done_cnt, 1);
        check({name, ":reads"}, n_reads, stuck ? 0 : 2);
        check({name, ":ts_read_seen"}, saw_ts, !stuck);
        if (stuck) check({name, ":last_read"}, last_read, TO - 1);
        check({name, ":idle_busy"}, busy, 0);
    endtask

    task automatic spurious_beats(input string name);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            avm_readdatavalid = 1'b1;
            avm_readdata = $urandom;
        end
        @(negedge clock);
        avm_readdatavalid = 1'b0;
        @(negedge clock);
        check({name, ":id_value"}, id_value, m_id);
        check({name, ":ts_value"}, ts_value, m_ts);
        check({name, ":busy"}, busy, 0);
        check({name, ":done"}, done, 0);
        check({name, ":read"}, avm_read, 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;

        run_check("zero_wait", 0, 1, 0, 1, EXP_ID, EXP_TS, 0, -1, -1);
        run_check("id_mismatch", 0, 1, 0, 1, 32'hACD5_1303, EXP_TS, 0, -1, -1);
        run_check("stall3", 3, 1, 3, 1, EXP_ID, EXP_TS, 0, -1, -1);
        run_check("stuck", 0, 1, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 1, -1, -1);
        run_check("restart", 0, 1, 0, 1, EXP_ID, 32'h5711_7CE2, 0, 1, -1);
        spurious_beats("spurious");
        run_check("reset_mid", 0, 1, 0, 1, EXP_ID, EXP_TS, 0, -1, 3);
        run_check("after_reset", 0, 1, 0, 1, EXP_ID, EXP_TS, 0, -1, -1);

        for (int i = 0; i < 10; i++) begin
            r_wi = $urandom_range(0, 3);
            r_li = $urandom_range(1, 3);
            r_wt = $urandom_range(0, 3);
            r_lt = $urandom_range(1, 3);
            r_di = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            r_dt = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            run_check($sformatf("rand%0d", i), r_wi, r_li, r_wt, r_lt, r_di, r_dt, 0, -1, -1);
        end
        spurious_beats("spurious_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/soc_system_sysid_checker.md
# soc_system_sysid_checker

Avalon-MM read master that sits on the lightweight HPS-to-FPGA fabric opposite the system-ID slave and checks, in hardware, that the loaded FPGA image matches the build the PUF software expects. On a start pulse it reads the ID word at address 0 and the timestamp word at address 1, compares both against build-time constants, and reports pass/fail/timeout status. It gates PUF challenge logic until the image is confirmed.

## Interface
- EXPECTED_ID, 32'hACD5_1302, system ID value expected at address 0
- EXPECTED_TIMESTAMP, 32'h5711_7CE3, build timestamp expected at address 1
- TIMEOUT_CYCLES, 255, max cycles per read transaction (request + response) before abort; ≥ 2
- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check; ignored while busy
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of a check
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- pass  out  1  id_ok & ts_ok & !timeout
- timeout  out  1  last check aborted on timeout
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE: start=1 → ID_REQ; clear id_ok, ts_ok, pass, timeout; id_value/ts_value retained.
- ID_REQ: avm_read=1, avm_address=0; hold while avm_waitrequest=1; read & !waitrequest → ID_WAIT.
- ID_WAIT: avm_read=0; on avm_readdatavalid capture id_value, set id_ok = (readdata == EXPECTED_ID) → TS_REQ.
- TS_REQ/TS_WAIT: same with avm_address=1, capturing ts_value/ts_ok → DONE.
- DONE: done=1 for one cycle, pass updated; → IDLE.
- Timeout counter: cleared on entry to each *_REQ state, increments every cycle in *_REQ/*_WAIT; reaching TIMEOUT_CYCLES → DONE with timeout=1, avm_read dropped immediately (deliberate abort, only on failure path), no further reads.
- readdatavalid in IDLE, *_REQ or DONE is ignored; readdata is not sampled then.
- ID mismatch does not skip the timestamp read; both words are always read.
- start while busy (any state ≠ IDLE) is ignored, no queuing.
- Status outputs (id_ok, ts_ok, pass, timeout) hold from DONE until the next accepted start.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Reset asserted mid-check: avm_read drops asynchronously, no done pulse; after release, IDLE, waiting for new start.
- All outputs registered; avm_read/avm_address stable while waitrequest=1.
- start sampled at edge E0 → avm_read=1 from E0 to E1.
- Zero-wait slave, readdatavalid one cycle after acceptance: ID accepted E1, data E2, TS accepted E3, data E4, done high E5–E6; busy high E0–E5.
- Each waitrequest cycle or extra response cycle adds one cycle per transaction.
- Timeout: abort at the TIMEOUT_CYCLES-th cycle of a transaction; done follows on the next edge.
- busy = (state ≠ IDLE); done and busy never both low during a check.

## Structure
- Shared package soc_system_pkg: state enum, SYSID_ADDR_ID = 1'b0, SYSID_ADDR_TS = 1'b1, default expected-value constants.
- Single module, no sub-modules; timeout counter width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Zero-wait slave returning 32'hACD5_1302 / 32'h5711_7CE3, start pulse → done at E5, pass=1, id_ok=ts_ok=1, timeout=0.
- Slave returns 32'hACD5_1303 for ID → both reads still issued, id_ok=0, ts_ok=1, pass=0, id_value=32'hACD5_1303.
- waitrequest held 3 cycles on each read → done at E11, avm_address/avm_read stable during stalls, pass=1.
- TIMEOUT_CYCLES=16, waitrequest stuck high → avm_read drops after 16 cycles, done next cycle, timeout=1, pass=0, no address-1 read.
- start re-pulsed at E2 and spurious readdatavalid in IDLE → ignored; single done pulse, captured values unchanged by the spurious beat.
- reset_n low during TS_WAIT → all outputs 0 asynchronously; after release a new start completes with pass=1.
